// File: rtl/spi_rd_master.sv
// Host-side SPI read initiator: sends CMD_RD with DC low, then clocks DATA_BYTES bytes in with DC high.
// Optional per-byte stream outputs (byte_vld_o/byte_data_o) are built only when SPI_RD_BYTE_STREAM_EN is defined.
module spi_rd_master #(
  parameter int         CLK_DIV    = 2,
  parameter int         DATA_BYTES = 7,
  parameter logic [7:0] CMD_RD     = 8'h3b
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [DATA_BYTES*8-1:0] data_o,
  output logic                    spi_sclk_o,
  output logic                    spi_cs_n_o,
  output logic                    spi_dc_o,
  output logic                    spi_mosi_o,
  input  logic                    spi_miso_i
`ifdef SPI_RD_BYTE_STREAM_EN
  ,
  output logic                    byte_vld_o,
  output logic [7:0]              byte_data_o
`endif
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BYTE_W = $clog2(DATA_BYTES + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(DATA_BYTES);

  typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

  state_t                  r_state;
  logic [DIV_W-1:0]        r_div;
  logic [2:0]              r_bit;
  logic [BYTE_W-1:0]       r_byte;
  logic [7:0]              r_tx;
  logic [7:0]              r_rx;
  logic [DATA_BYTES*8-1:0] r_shadow;

  logic       w_tick;
  logic [7:0] w_rx_next;

  assign w_tick    = (r_div == DIV_LAST);
  assign w_rx_next = {r_rx[6:0], spi_miso_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_tx       <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      data_o     <= '0;
      spi_sclk_o <= 1'b0;
      spi_cs_n_o <= 1'b1;
      spi_dc_o   <= 1'b0;
      spi_mosi_o <= 1'b0;
`ifdef SPI_RD_BYTE_STREAM_EN
      byte_vld_o  <= 1'b0;
      byte_data_o <= '0;
`endif
    end else begin
      done_o <= 1'b0;
`ifdef SPI_RD_BYTE_STREAM_EN
      byte_vld_o <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (start_i) begin
            busy_o     <= 1'b1;
            spi_cs_n_o <= 1'b0;
            spi_dc_o   <= 1'b0;
            spi_sclk_o <= 1'b0;
            spi_mosi_o <= CMD_RD[7];
            r_tx       <= {CMD_RD[6:0], 1'b0};
            r_div      <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_state    <= CMD;
          end
        end
        CMD, DATA: begin
          if (!w_tick) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div <= '0;
            if (!spi_sclk_o) begin
              // Rising SCLK: MISO is captured on this same clk edge.
              spi_sclk_o <= 1'b1;
              if (r_state == DATA) begin
                r_rx <= w_rx_next;
                if (r_bit == 3'd7) begin
                  r_shadow[8*r_byte +: 8] <= w_rx_next;
                  r_byte                  <= r_byte + 1'b1;
`ifdef SPI_RD_BYTE_STREAM_EN
                  byte_vld_o  <= 1'b1;
                  byte_data_o <= w_rx_next;
`endif
                end
              end
            end else begin
              // Falling SCLK: the only place MOSI/DC move after T0.
              spi_sclk_o <= 1'b0;
              r_bit      <= r_bit + 1'b1;
              if (r_state == CMD) begin
                if (r_bit == 3'd7) begin
                  spi_dc_o   <= 1'b1;
                  spi_mosi_o <= 1'b0;
                  r_state    <= DATA;
                end else begin
                  spi_mosi_o <= r_tx[7];
                  r_tx       <= {r_tx[6:0], 1'b0};
                end
              end else if (r_bit == 3'd7 && r_byte == BYTE_LAST) begin
                r_state <= HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (!w_tick) begin
            r_div <= r_div + 1'b1;
          end else begin
            r_div      <= '0;
            spi_cs_n_o <= 1'b1;
            spi_dc_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            data_o     <= r_shadow;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rd_master.sv
// Directed bench for spi_rd_master: default instance (CLK_DIV=2, 7 bytes) and a CLK_DIV=3, 2-byte instance.
// Define SPI_RD_BYTE_STREAM_EN to also exercise the per-byte stream outputs.
module tb_spi_rd_master;
  localparam int CD_A  = 2;
  localparam int DB_A  = 7;
  localparam int CD_B  = 3;
  localparam int DB_B  = 2;
  localparam int LAT_A = 16*CD_A*(1+DB_A) + CD_A;   // 258 cycles after T0
  localparam int LAT_B = 16*CD_B*(1+DB_B) + CD_B;   // 147 cycles after T0

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic a_busy, a_done, a_sclk, a_cs_n, a_dc, a_mosi, a_miso;
  logic [DB_A*8-1:0] a_data;
  logic b_busy, b_done, b_sclk, b_cs_n, b_dc, b_mosi, b_miso;
  logic [DB_B*8-1:0] b_data;
`ifdef SPI_RD_BYTE_STREAM_EN
  logic a_vld, b_vld;
  logic [7:0] a_bdata, b_bdata;
`endif

  spi_rd_master u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(a_busy), .done_o(a_done),
    .data_o(a_data), .spi_sclk_o(a_sclk), .spi_cs_n_o(a_cs_n), .spi_dc_o(a_dc),
    .spi_mosi_o(a_mosi), .spi_miso_i(a_miso)
`ifdef SPI_RD_BYTE_STREAM_EN
    , .byte_vld_o(a_vld), .byte_data_o(a_bdata)
`endif
  );

  spi_rd_master #(.CLK_DIV(CD_B), .DATA_BYTES(DB_B), .CMD_RD(8'h3b)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(b_busy), .done_o(b_done),
    .data_o(b_data), .spi_sclk_o(b_sclk), .spi_cs_n_o(b_cs_n), .spi_dc_o(b_dc),
    .spi_mosi_o(b_mosi), .spi_miso_i(b_miso)
`ifdef SPI_RD_BYTE_STREAM_EN
    , .byte_vld_o(b_vld), .byte_data_o(b_bdata)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave A: byte k of sa_word is the k-th data byte returned; MOSI/DC recorded per SCLK rise.
  logic [DB_A*8-1:0] sa_word = '0;
  logic [63:0] sa_tx = '0, sa_rx = '0, sa_dcv = '0;
  int sa_rise = 0;
  always @(posedge a_sclk or negedge a_cs_n) begin
    if (!a_sclk) begin
      sa_rise = 0;
      sa_tx   = '0;
      for (int k = 0; k < DB_A; k++) sa_tx = {sa_tx[55:0], sa_word[8*k +: 8]};
    end else begin
      sa_rise++;
      sa_rx  = {sa_rx[62:0], a_mosi};
      sa_dcv = {sa_dcv[62:0], a_dc};
      sa_tx  = {sa_tx[62:0], 1'b0};
    end
  end
  assign a_miso = sa_tx[63];

  logic [DB_B*8-1:0] sb_word = '0;
  logic [23:0] sb_tx = '0;
  int sb_rise = 0;
  always @(posedge b_sclk or negedge b_cs_n) begin
    if (!b_sclk) begin
      sb_rise = 0;
      sb_tx   = '0;
      for (int k = 0; k < DB_B; k++) sb_tx = {sb_tx[15:0], sb_word[8*k +: 8]};
    end else begin
      sb_rise++;
      sb_tx = {sb_tx[22:0], 1'b0};
    end
  end
  assign b_miso = sb_tx[23];

  int a_first, a_ndone;
  bit a_early;
  logic [DB_A*8-1:0] a_prev, snap_data;
  logic t0_busy, t0_cs, t0_dc, t0_mosi, snap_cs, snap_sclk, snap_busy;
  int vld_cnt, vld_bad, vld_gap_bad, vld_first, vld_prev;

  // t counts cycles from T0 (first cycle with busy high); rs >= 0 pulses reset at T0+rs.
  task automatic run_a(input int p1, input int p2, input int rs, input int lim);
    a_prev = a_data; a_first = -1; a_ndone = 0; a_early = 1'b0;
    vld_cnt = 0; vld_bad = 0; vld_gap_bad = 0; vld_first = -1; vld_prev = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int t = 0; t <= lim; t++) begin
      if (t == 0) begin
        t0_busy = a_busy; t0_cs = a_cs_n; t0_dc = a_dc; t0_mosi = a_mosi;
      end
      if (a_done) begin
        a_ndone++;
        if (a_first < 0) a_first = t;
      end else if (a_ndone == 0 && a_data !== a_prev) begin
        a_early = 1'b1;
      end
      if (rs >= 0 && t == rs + 1) begin
        snap_cs = a_cs_n; snap_sclk = a_sclk; snap_busy = a_busy; snap_data = a_data;
      end
`ifdef SPI_RD_BYTE_STREAM_EN
      if (a_vld) begin
        if (a_bdata !== 8'hA5) vld_bad++;
        if (vld_cnt > 0 && (t - vld_prev) != 16*CD_A) vld_gap_bad++;
        if (vld_cnt == 0) vld_first = t;
        vld_prev = t;
        vld_cnt++;
      end
`endif
      start_a = (t == p1 || t == p2);
      rst     = (t == rs);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    rst     = 1'b0;
  endtask

  int b_first, hi_min, hi_max, lo_min, lo_max;

  task automatic run_b(input int lim);
    int   run;
    logic prev_s;
    b_first = -1; hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0; run = 0;
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    prev_s = b_sclk;
    for (int t = 0; t <= lim; t++) begin
      if (b_done && b_first < 0) b_first = t;
      if (t > 0 && b_sclk !== prev_s) begin
        if (prev_s) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        run = 1;
      end else begin
        run++;
      end
      prev_s = b_sclk;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(a_busy), 64'd0);
    check_eq("rst_done", 64'(a_done), 64'd0);
    check_eq("rst_data", 64'(a_data), 64'd0);
    check_eq("rst_sclk", 64'(a_sclk), 64'd0);
    check_eq("rst_cs_n", 64'(a_cs_n), 64'd1);
    check_eq("rst_dc",   64'(a_dc),   64'd0);
    check_eq("rst_mosi", 64'(a_mosi), 64'd0);
    check_eq("rst_b_cs_n", 64'(b_cs_n), 64'd1);
    check_eq("rst_b_data", 64'(b_data), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic read with default parameters
    sa_word = 56'h77665544332211;
    run_a(-1, -1, -1, LAT_A + 4);
    check_eq("t0_busy", 64'(t0_busy), 64'd1);
    check_eq("t0_cs_n", 64'(t0_cs),   64'd0);
    check_eq("t0_dc",   64'(t0_dc),   64'd0);
    check_eq("t0_mosi", 64'(t0_mosi), 64'd0);
    check_eq("basic_latency", 64'(a_first), 64'(LAT_A));
    check_eq("basic_ndone",   64'(a_ndone), 64'd1);
    check_eq("basic_data",    64'(a_data),  64'h0077665544332211);
    check_eq("basic_cmd_byte", 64'(sa_rx[63:56]),  64'h3b);
    check_eq("basic_cmd_dc",   64'(sa_dcv[63:56]), 64'h00);
    check_eq("basic_data_mosi", 64'(sa_rx[55:0]),  64'd0);
    check_eq("basic_data_dc",   64'(sa_dcv[55:0]), 64'h00ffffffffffffff);
    check_eq("basic_rises",   64'(sa_rise), 64'd64);
    check_eq("basic_idle_busy", 64'(a_busy), 64'd0);
    check_eq("basic_idle_cs_n", 64'(a_cs_n), 64'd1);

    // start pulses while busy must be ignored
    sa_word = 56'h563412efbeadde;
    run_a(10, 60, -1, LAT_A + 4);
    check_eq("busy_no_early_update", 64'(a_early), 64'd0);
    check_eq("busy_ndone",   64'(a_ndone), 64'd1);
    check_eq("busy_latency", 64'(a_first), 64'(LAT_A));
    check_eq("busy_data",    64'(a_data),  64'h00563412efbeadde);

    // Reset in the middle of a transfer, then a clean read
    sa_word = 56'hffffffffffffff;
    run_a(-1, -1, 40, LAT_A + 4);
    check_eq("midrst_cs_n", 64'(snap_cs),   64'd1);
    check_eq("midrst_sclk", 64'(snap_sclk), 64'd0);
    check_eq("midrst_busy", 64'(snap_busy), 64'd0);
    check_eq("midrst_data", 64'(snap_data), 64'd0);
    check_eq("midrst_ndone", 64'(a_ndone),  64'd0);
    sa_word = 56'h02040810204080;
    run_a(-1, -1, -1, LAT_A + 4);
    check_eq("after_rst_latency", 64'(a_first), 64'(LAT_A));
    check_eq("after_rst_data",    64'(a_data),  64'h0002040810204080);

    // CLK_DIV=3, two data bytes
    sb_word = 16'h5ac3;
    run_b(LAT_B + 3);
    check_eq("b_hi_min", 64'(hi_min), 64'd3);
    check_eq("b_hi_max", 64'(hi_max), 64'd3);
    check_eq("b_lo_min", 64'(lo_min), 64'd3);
    check_eq("b_lo_max", 64'(lo_max), 64'd3);
    check_eq("b_rises",  64'(sb_rise), 64'd24);
    check_eq("b_latency", 64'(b_first), 64'(LAT_B));
    check_eq("b_data",   64'(b_data), 64'h5ac3);

`ifdef SPI_RD_BYTE_STREAM_EN
    sa_word = 56'ha5a5a5a5a5a5a5;
    run_a(-1, -1, -1, LAT_A + 4);
    check_eq("stream_count",    64'(vld_cnt),     64'(DB_A));
    check_eq("stream_bad_byte", 64'(vld_bad),     64'd0);
    check_eq("stream_bad_gap",  64'(vld_gap_bad), 64'd0);
    check_eq("stream_not_in_cmd", 64'(vld_first >= 16*CD_A), 64'd1);
    check_eq("stream_before_done", 64'(vld_prev < a_first), 64'd1);
    check_eq("stream_data", 64'(a_data), 64'h00a5a5a5a5a5a5a5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
